gate_share_arb: RTL

- Shares one 2-input logic gate between NREQ requesters.
- Each requester submits a WIDTH-bit operand and an opcode. The block reduces the operand serially, one bit per cycle, through the shared gate, then returns the result with the requester ID.
- Sits between the lab's multi-input gate users and the single primitive gate cell. It replaces replicated gate trees with a time-multiplexed unit.

---
 rtl/gate_share_arb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/gate_share_arb.sv
// gate_share_arb: time-multiplexes a single 2-input gate between NREQ
// requesters. A granted operand is reduced one bit per cycle and the
// result is returned together with the requester index.
module gate_share_arb #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic [NREQ*2-1:0]       req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_result,
    output logic [IDW-1:0]          rsp_id
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [WIDTH-1:0]     sh_q;
    logic                 acc_q;
    logic [CW-1:0]        cnt_q;
    logic [1:0]           op_q;
    logic [IDW-1:0]       id_q;
    logic [IDW-1:0]       last_q;

    logic                 grant_found;
    logic [NREQ-1:0]      grant_oh;
    logic [IDW-1:0]       grant_idx;
    logic [WIDTH-1:0]     sel_data;
    logic [1:0]           sel_op;
    logic                 accept;
    logic                 next_acc;

    // Round-robin search: first pass covers indices above last, second pass wraps to the rest.
    always_comb begin
        grant_found = 1'b0;
        grant_oh    = '0;
        grant_idx   = '0;
        sel_data    = '0;
        sel_op      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && req_valid[i] && (i > int'(last_q))) begin
                grant_found = 1'b1;
                grant_oh[i] = 1'b1;
                grant_idx   = IDW'(i);
                sel_data    = req_data[i*WIDTH +: WIDTH];
                sel_op      = req_op[i*2 +: 2];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && req_valid[i] && (i <= int'(last_q))) begin
                grant_found = 1'b1;
                grant_oh[i] = 1'b1;
                grant_idx   = IDW'(i);
                sel_data    = req_data[i*WIDTH +: WIDTH];
                sel_op      = req_op[i*2 +: 2];
            end
        end
    end

    // Shared gate: NAND is reduced as AND and inverted once at the end.
    always_comb begin
        case (op_q)
            2'b01:   next_acc = acc_q | sh_q[0];
            2'b10:   next_acc = acc_q ^ sh_q[0];
            default: next_acc = acc_q & sh_q[0];
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and ready logic; ready is held low while reset is asserted.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found && rst_n) begin
                    req_ready = grant_oh;
                    accept    = 1'b1;
                    state_d   = (WIDTH > 1) ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift and reduce in BUSY, present the result on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q       <= '0;
            acc_q      <= 1'b0;
            cnt_q      <= '0;
            op_q       <= '0;
            id_q       <= '0;
            last_q     <= IDW'(NREQ - 1);
            rsp_valid  <= 1'b0;
            rsp_result <= 1'b0;
            rsp_id     <= '0;
        end else begin
            if (accept) begin
                sh_q   <= sel_data >> 1;
                acc_q  <= sel_data[0];
                cnt_q  <= CW'(1);
                op_q   <= sel_op;
                id_q   <= grant_idx;
                last_q <= grant_idx;
                if (WIDTH == 1) begin
                    rsp_valid  <= 1'b1;
                    rsp_result <= sel_data[0] ^ (sel_op == 2'b11);
                    rsp_id     <= grant_idx;
                end
            end else if (state_q == BUSY) begin
                acc_q <= next_acc;
                sh_q  <= sh_q >> 1;
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    rsp_valid  <= 1'b1;
                    rsp_result <= next_acc ^ (op_q == 2'b11);
                    rsp_id     <= id_q;
                end
            end else if ((state_q == DONE) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
